imm_enc: RTL and testbench

Immediate encoder: the inverse of the pipeline's immediate generator. Takes a 32-bit immediate, a one-hot immediate-type select and a base instruction word, and produces the instruction with the immediate scattered into the RISC-V bit positions for that type. Non-immediate fields come from the base word unchanged. It sits in the branch-predictor / instruction-patch path, where computed branch and jump targets are re-encoded into instruction words. It is a 2-stage valid/ready pipeline with error detection and statistics counters.

---
 rtl/imm_enc.sv | 167 ++++++++++++++++
 tb/tb_imm_enc.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_enc.sv
// imm_enc - immediate encoder, the inverse of the pipeline's immediate
// generator. It scatters a 32-bit immediate into the RISC-V bit positions of
// the selected immediate type. All other bits of the base instruction pass
// through unchanged. Used in the branch-predictor / instruction-patch path.
//
// Pipeline: two stages with valid/ready handshaking.
//   S1 captures the request together with its encoded word and error flag.
//   S2 is the output register.
// Latency is 2 cycles. Throughput is 1 word/cycle. At most 2 requests are in
// flight.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid / o_ready    request handshake
//   i_imm[31:0]          immediate, two's complement
//   i_imm_sel[4:0]       one-hot type select {U, UJ, B, S, I}
//   i_base[31:0]         base instruction word
//   o_valid / i_ready    output handshake
//   o_inst[31:0]         encoded instruction
//   o_err                illegal request flag, qualified by o_valid
//   i_clr                synchronous clear of both counters (beats increment)
//   o_enc_cnt[15:0]      completed output handshakes, saturating
//   o_err_cnt[15:0]      completed handshakes with o_err=1, saturating
//
// Build option: define IMM_ENC_RANGE_CHECK_EN to also flag immediates that do
// not fit the selected type. The output word is still the truncated encoding.
module imm_enc (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_imm_sel,
  input  logic [31:0] i_base,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic        o_err,
  input  logic        i_clr,
  output logic [15:0] o_enc_cnt,
  output logic [15:0] o_err_cnt
);

  typedef enum logic [4:0] {
    SEL_I  = 5'b00001,
    SEL_S  = 5'b00010,
    SEL_B  = 5'b00100,
    SEL_UJ = 5'b01000,
    SEL_U  = 5'b10000
  } imm_sel_e;

  logic        s1_valid;
  logic [31:0] s1_inst;
  logic        s1_err;

  logic        s2_adv;
  logic        s1_load;
  logic        out_hs;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        sel_bad;
  logic        range_bad;

  assign s2_adv  = !o_valid || i_ready;
  assign o_ready = !s1_valid || s2_adv;
  assign s1_load = o_ready;
  assign out_hs  = o_valid && i_ready;

  // One-hot check: zero, or more than one bit set, is illegal.
  assign sel_bad = (i_imm_sel == '0) || ((i_imm_sel & (i_imm_sel - 5'd1)) != '0);

  always_comb begin
    enc_inst = i_base;
    case (i_imm_sel)
      SEL_I: begin
        enc_inst[31:20] = i_imm[11:0];
      end
      SEL_S: begin
        enc_inst[31:25] = i_imm[11:5];
        enc_inst[11:7]  = i_imm[4:0];
      end
      SEL_B: begin
        enc_inst[31]    = i_imm[12];
        enc_inst[7]     = i_imm[11];
        enc_inst[30:25] = i_imm[10:5];
        enc_inst[11:8]  = i_imm[4:1];
      end
      SEL_UJ: begin
        enc_inst[31]    = i_imm[20];
        enc_inst[30:21] = i_imm[10:1];
        enc_inst[20]    = i_imm[11];
        enc_inst[19:12] = i_imm[19:12];
      end
      SEL_U: begin
        enc_inst[31:12] = i_imm[31:12];
      end
      default: begin
        enc_inst = i_base;
      end
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  // The value fits a signed field when every bit above the field's sign bit
  // equals that sign bit. Branch and jump offsets must also be even.
  always_comb begin
    range_bad = 1'b0;
    case (i_imm_sel)
      SEL_I, SEL_S: range_bad = !((&i_imm[31:11]) || (~|i_imm[31:11]));
      SEL_B:        range_bad = !((&i_imm[31:12]) || (~|i_imm[31:12])) || i_imm[0];
      SEL_UJ:       range_bad = !((&i_imm[31:20]) || (~|i_imm[31:20])) || i_imm[0];
      SEL_U:        range_bad = (i_imm[11:0] != '0);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign enc_err = sel_bad || range_bad;

  // S1: request register. It holds while S2 is stuck under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_inst <= enc_inst;
        s1_err  <= enc_err;
      end
    end
  end

  // S2: output register. It is stable while o_valid && !i_ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_inst  <= '0;
      o_err   <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_inst <= s1_inst;
        o_err  <= s1_err;
      end
    end
  end

  // Statistics counters. They saturate at all-ones, and clear takes priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_enc_cnt <= '0;
      o_err_cnt <= '0;
    end else if (i_clr) begin
      o_enc_cnt <= '0;
      o_err_cnt <= '0;
    end else if (out_hs) begin
      if (o_enc_cnt != '1) o_enc_cnt <= o_enc_cnt + 16'd1;
      if (o_err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
module tb_imm_enc;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_imm;
  logic [4:0]  i_imm_sel;
  logic [31:0] i_base;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic        o_err;
  logic        i_clr;
  logic [15:0] o_enc_cnt;
  logic [15:0] o_err_cnt;

  imm_enc dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_imm     (i_imm),
    .i_imm_sel (i_imm_sel),
    .i_base    (i_base),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_inst    (o_inst),
    .o_err     (o_err),
    .i_clr     (i_clr),
    .o_enc_cnt (o_enc_cnt),
    .o_err_cnt (o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Type index: 0=I 1=S 2=B 3=UJ 4=U, or -1 for an illegal select.
  function automatic int sel_type(input logic [4:0] sel);
    if ($countones(sel) != 1) return -1;
    for (int k = 0; k < 5; k++) if (sel[k]) return k;
    return -1;
  endfunction

  // For instruction bit pos of type t, return the immediate bit it carries.
  // Return -1 when the bit passes through from the base word.
  function automatic int src_bit(input int t, input int pos);
    case (t)
      0: return (pos >= 20) ? pos - 20 : -1;
      1: if (pos >= 25) return pos - 20;
         else if (pos >= 7 && pos <= 11) return pos - 7;
         else return -1;
      2: if (pos == 31) return 12;
         else if (pos == 7) return 11;
         else if (pos >= 25) return pos - 20;
         else if (pos >= 8 && pos <= 11) return pos - 7;
         else return -1;
      3: if (pos == 31) return 20;
         else if (pos >= 21) return pos - 20;
         else if (pos == 20) return 11;
         else if (pos >= 12) return pos;
         else return -1;
      4: return (pos >= 12) ? pos : -1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_enc(input int t, input logic [31:0] imm,
                                            input logic [31:0] base);
    logic [31:0] r;
    r = base;
    for (int pos = 0; pos < 32; pos++) begin
      int s;
      s = src_bit(t, pos);
      if (s >= 0) r[pos] = imm[s];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_dec(input int t, input logic [31:0] inst);
    logic [31:0] r;
    int top;
    r = '0;
    top = 0;
    for (int pos = 0; pos < 32; pos++) begin
      int s;
      s = src_bit(t, pos);
      if (s >= 0) begin
        r[s] = inst[pos];
        if (s > top) top = s;
      end
    end
    for (int b = top + 1; b < 32; b++) r[b] = r[top];
    return r;
  endfunction

  function automatic bit model_fit(input int t, input logic [31:0] imm);
    int v;
    v = int'(imm);
    case (t)
      0, 1: return (v >= -2048) && (v <= 2047);
      2: return (v >= -4096) && (v <= 4094) && !imm[0];
      3: return (v >= -1048576) && (v <= 1048574) && !imm[0];
      4: return imm[11:0] == 12'h000;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_err(input int t, input logic [31:0] imm);
    if (t < 0) return 1'b1;
`ifdef IMM_ENC_RANGE_CHECK_EN
    return !model_fit(t, imm);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] imm;
    int          t;
    bit          fit;
  } exp_t;

  exp_t        q[$];
  int unsigned m_enc = 0;
  int unsigned m_errc = 0;
  int          vcount = 0;
  bit          hold = 0;
  logic [31:0] h_inst;
  logic        h_err;

  // Compare process: checks outputs at every falling edge, away from the
  // active rising edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      q.delete();
      m_enc  = 0;
      m_errc = 0;
      hold   = 0;
    end else begin
      bit   pop_err;
      exp_t e;
      pop_err = 1'b0;
      check("enc_cnt", {16'h0, o_enc_cnt}, m_enc);
      check("err_cnt", {16'h0, o_err_cnt}, m_errc);
      if (hold) begin
        check("hold_inst", o_inst, h_inst);
        check("hold_err", {31'h0, o_err}, {31'h0, h_err});
      end
      if (o_valid && i_ready) begin
        vcount++;
        check("out_expected", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          pop_err = e.err;
          check("stream_inst", o_inst, e.inst);
          check("stream_err", {31'h0, o_err}, {31'h0, e.err});
          if (e.t >= 0 && e.fit) check("round_trip", model_dec(e.t, o_inst), e.imm);
        end
      end
      hold   = o_valid && !i_ready;
      h_inst = o_inst;
      h_err  = o_err;
      if (i_clr) begin
        m_enc  = 0;
        m_errc = 0;
      end else if (o_valid && i_ready) begin
        if (m_enc < 32'hFFFF) m_enc++;
        if (pop_err && m_errc < 32'hFFFF) m_errc++;
      end
      if (i_valid && o_ready) begin
        e.t    = sel_type(i_imm_sel);
        e.imm  = i_imm;
        e.inst = (e.t < 0) ? i_base : model_enc(e.t, i_imm, i_base);
        e.err  = model_err(e.t, i_imm);
        e.fit  = (e.t >= 0) && model_fit(e.t, i_imm);
        q.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+#1. Returns at posedge+#1 right after the accept edge.
  task automatic send(input logic [4:0] sel, input logic [31:0] imm, input logic [31:0] base);
    i_valid   = 1'b1;
    i_imm_sel = sel;
    i_imm     = imm;
    i_base    = base;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        return;
      end
      @(posedge i_clk); #1;
    end
    check("send_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic rand_legal(output logic [4:0] sel, output logic [31:0] imm);
    int t;
    logic [31:0] r;
    t = $urandom_range(0, 4);
    r = $urandom;
    sel = 5'b00001 << t;
    case (t)
      0, 1: imm = {{20{r[11]}}, r[11:0]};
      2:    imm = {{19{r[12]}}, r[12:1], 1'b0};
      3:    imm = {{11{r[20]}}, r[20:1], 1'b0};
      default: imm = {r[31:12], 12'h000};
    endcase
  endtask

  initial begin
    logic [4:0]  sel;
    logic [31:0] imm;
    int          v0;
    int          acc;
    logic [15:0] ec;

    i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1; i_clr = 1'b0;
    i_imm = 32'h00000123; i_imm_sel = 5'b00001; i_base = 32'h00000013;

    // Reset held with a valid request pending.
    idle(3);
    check("rst_o_valid", {31'h0, o_valid}, 32'd0);
    check("rst_o_inst", o_inst, 32'h0);
    check("rst_enc_cnt", {16'h0, o_enc_cnt}, 32'd0);
    check("rst_err_cnt", {16'h0, o_err_cnt}, 32'd0);
    i_rst_n = 1'b1; i_valid = 1'b0;
    idle(1);
    check("rst_o_ready", {31'h0, o_ready}, 32'd1);

    // B-type: offset -8.
    send(5'b00100, 32'hFFFFFFF8, 32'h00000063);
    check("b_lat_not_yet", {31'h0, o_valid}, 32'd0);
    idle(1);
    check("b_valid", {31'h0, o_valid}, 32'd1);
    check("b_inst", o_inst, 32'hFE000CE3);
    check("b_err", {31'h0, o_err}, 32'd0);
    check("b_decode", model_dec(2, o_inst), 32'hFFFFFFF8);
    idle(2);

    // Illegal select.
    ec = o_err_cnt;
    send(5'b00011, 32'h00000555, 32'h12345678);
    idle(1);
    check("sel_inst", o_inst, 32'h12345678);
    check("sel_err", {31'h0, o_err}, 32'd1);
    idle(1);
    check("sel_err_cnt", {16'h0, o_err_cnt}, {16'h0, ec + 16'd1});

    // I-type immediate just out of range.
    send(5'b00001, 32'd2048, 32'h00000013);
    idle(1);
    check("i_range_inst", o_inst, 32'h80000013);
`ifdef IMM_ENC_RANGE_CHECK_EN
    check("i_range_err", {31'h0, o_err}, 32'd1);
`else
    check("i_range_err", {31'h0, o_err}, 32'd0);
`endif
    idle(2);

    // Streaming: 100 legal requests back to back.
    i_clr = 1'b1; idle(1); i_clr = 1'b0;
    v0 = vcount;
    for (int k = 0; k < 100; k++) begin
      rand_legal(sel, imm);
      send(sel, imm, $urandom);
    end
    check("stream_consec_a", vcount - v0, 32'd98);
    idle(2);
    check("stream_consec_b", vcount - v0, 32'd100);
    idle(1);
    check("stream_enc_cnt", {16'h0, o_enc_cnt}, 32'd100);
    check("stream_err_cnt", {16'h0, o_err_cnt}, 32'd0);

    // Backpressure: i_ready low for 5 cycles with i_valid held high.
    i_ready = 1'b0;
    acc = 0;
    i_valid = 1'b1;
    rand_legal(sel, imm);
    i_imm_sel = sel; i_imm = imm; i_base = $urandom;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (o_ready) acc++;
      @(posedge i_clk); #1;
      rand_legal(sel, imm);
      i_imm_sel = sel; i_imm = imm; i_base = $urandom;
    end
    check("bp_accepts", acc, 32'd2);
    check("bp_o_ready", {31'h0, o_ready}, 32'd0);
    check("bp_o_valid", {31'h0, o_valid}, 32'd1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    idle(3);
    check("bp_drained", q.size(), 32'd0);

    // Counters: preload to FFFE, then saturate.
    i_clr = 1'b1; idle(1); i_clr = 1'b0;
    for (int k = 0; k < 65534; k++) send(5'b00001, k & 32'h7FF, 32'h00000013);
    idle(3);
    check("cnt_fffe", {16'h0, o_enc_cnt}, 32'h0000FFFE);
    send(5'b10000, 32'hABCDE000, 32'h00000037);
    send(5'b00000, 32'h00000000, 32'h00000033);
    idle(3);
    check("cnt_ffff", {16'h0, o_enc_cnt}, 32'h0000FFFF);
    check("cnt_err_one", {16'h0, o_err_cnt}, 32'd1);
    send(5'b00001, 32'h00000001, 32'h00000013);
    idle(3);
    check("cnt_hold", {16'h0, o_enc_cnt}, 32'h0000FFFF);

    // Clear coincides with an output handshake.
    send(5'b00010, 32'h00000010, 32'h00000023);
    idle(1);
    check("clr_hs_valid", {31'h0, o_valid}, 32'd1);
    i_clr = 1'b1;
    idle(1);
    i_clr = 1'b0;
    check("clr_enc_cnt", {16'h0, o_enc_cnt}, 32'd0);
    check("clr_err_cnt", {16'h0, o_err_cnt}, 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
